mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Memory-stage load/store engine on the consumer side of the EX/MEM pipeline register.
- Takes the registered address (alu_result), store data, write-enable and func3.
- Runs a req/ready handshake to the data bus / memory-mapped peripheral space (including the I2C controller registers).
- Drives the stall back into the pipeline registers and delivers byte/half/word-aligned, sign- or zero-extended load data to MEM/WB.

Parameters:
- TIMEOUT, 255: maximum REQ-state cycles waiting for bus_ready before the access is force-completed (minimum 1).

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  synchronous active-high reset.
- flush  in  1  squash the access presented this cycle (IDLE only).
- in_mem_read  in  1  load present.
- in_wed  in  1  store present.
- in_func3  in  3  RV32I load/store funct3.
- in_addr  in  32  effective byte address.
- in_wdata  in  32  store data (rs2).
- bus_req  out  1  bus request, registered.
- bus_we  out  1  1 = write.
- bus_addr  out  32  word address, {in_addr[31:2],2'b00}.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_ready  in  1  transfer completes this cycle; bus_rdata valid for reads.
- bus_rdata  in  32  read data.
- o_stall  out  1  freeze upstream pipeline registers.
- o_read_data  out  32  extended load result.
- o_misaligned  out  1  one-cycle pulse: misaligned access rejected.
- o_bus_timeout  out  1  one-cycle pulse: access force-completed.

Behaviour:
- Reset: state=IDLE; bus_req, bus_we, bus_be, bus_addr, bus_wdata, o_read_data, o_misaligned, o_bus_timeout and the timeout counter are 0. o_stall is 0 after reset.
- Access decode:
  - access = (in_mem_read | in_wed) & !flush.
  - Write wins if both are set; read data is then untouched.
  - size = func3[1:0]: 0 byte, 1 half, 2/3 word. unsigned = func3[2], loads only.
  - Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
- FSM, states IDLE, REQ, DONE:
  - IDLE, access & aligned: latch bus_addr/bus_we/bus_be/bus_wdata, set bus_req=1, clear counter, go to REQ.
  - IDLE, access & misaligned: o_misaligned=1 next cycle for one cycle, no bus activity, stay IDLE.
  - REQ, bus_ready=1: bus_req=0. For loads, o_read_data <= extended bus_rdata. Go to DONE.
  - REQ, no ready and counter==TIMEOUT-1: bus_req=0, o_read_data <= 0 for loads, o_bus_timeout=1 for one cycle, go to DONE. Otherwise the counter increments.
  - DONE: unconditionally return to IDLE, without re-decoding the still-present inputs, so there is no duplicate access.
- o_stall (combinational): (IDLE & access & aligned) | REQ. Low in DONE, so the pipeline advances at the end of DONE and captures o_read_data.
- Latency:
  - Zero-wait bus: stall high 2 cycles; data valid in the DONE cycle.
  - Each wait cycle adds one stall cycle.
- Byte enables: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<{addr[1],1'b0}; word = 4'b1111.
- Write data: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
- Load extension: byte lane addr[1:0], half lane addr[1]. Signed = sign-extend lane MSB; unsigned = zero-extend.
- Bus stability: bus signals are held stable for the whole REQ state. bus_ready outside REQ is ignored.
- flush: only gates starting in IDLE. In REQ/DONE it is ignored, because the bus transaction cannot be cancelled.
- rst mid-REQ: next cycle IDLE with bus_req=0; the result is discarded.
- o_read_data holds its last load value through stores, misaligned rejects and idle cycles.

Test Plan:
- LW 0x0000_1000, bus_ready after 2 wait cycles, rdata 0xDEADBEEF -> bus_be=1111, o_stall high 4 cycles, o_read_data=0xDEADBEEF in DONE, bus_req low in DONE.
- LB (func3=0) 0x0000_1003, rdata 0x80123456 -> bus_addr 0x1000, o_read_data=0xFFFFFF80. Repeat as LBU (func3=4) -> 0x00000080. LHU 0x1002 -> 0x00008012.
- SH (func3=1) 0x0000_2002, wdata 0x1234ABCD -> bus_we=1, bus_be=1100, bus_wdata=0xABCDABCD, o_read_data unchanged.
- LW 0x0000_1001 -> o_misaligned pulse 1 cycle, bus_req never high, o_stall never high. Same test with flush=1 on an aligned LW -> no request, no stall.
- TIMEOUT=4, LW, bus_ready held 0 -> REQ exactly 4 cycles, o_bus_timeout pulse, o_read_data=0, back to IDLE.
- rst asserted on the 2nd REQ cycle -> next cycle bus_req=0, o_stall=0, o_read_data=0. A later load with immediate ready completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Memory-stage load/store engine sitting behind the EX/MEM pipeline register.
//   Decodes one load or store, runs a req/ready handshake on the data bus,
//   stalls the upstream pipeline while the transfer is outstanding, and returns
//   the lane-selected, sign- or zero-extended load result to MEM/WB.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   flush             squash the access presented this cycle (only honoured in IDLE)
//   in_mem_read       load present
//   in_wed            store present (wins over in_mem_read)
//   in_func3          RV32I load/store funct3
//   in_addr           effective byte address
//   in_wdata          store data
//   bus_req           registered bus request, held for the whole REQ state
//   bus_we            1 = write
//   bus_addr          word-aligned address
//   bus_be            byte enables
//   bus_wdata         lane-replicated store data
//   bus_ready         transfer completes this cycle (read data valid)
//   bus_rdata         read data
//   o_stall           freeze upstream pipeline registers
//   o_read_data       extended load result, valid from the DONE cycle on
//   o_misaligned      one-cycle pulse: misaligned access rejected
//   o_bus_timeout     one-cycle pulse: access force-completed after TIMEOUT cycles
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_mem_read,
    input  logic        in_wed,
    input  logic [2:0]  in_func3,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata,
    output logic        o_stall,
    output logic [31:0] o_read_data,
    output logic        o_misaligned,
    output logic        o_bus_timeout
);

    // Counter only needs to reach TIMEOUT-1.
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic             r_req;
    logic             r_we;
    logic [31:0]      r_addr;
    logic [3:0]       r_be;
    logic [31:0]      r_wdata;
    logic [1:0]       r_lane;
    logic [2:0]       r_func3;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_rdata;
    logic             r_misaligned;
    logic             r_timeout;

    logic             w_access;
    logic             w_misaligned;
    logic             w_cnt_last;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_ext;

    // Access decode
    assign w_access     = (in_mem_read | in_wed) & ~flush;
    assign w_misaligned = ((in_func3[1:0] == 2'b01) & in_addr[0])
                        | (in_func3[1] & (in_addr[1:0] != 2'b00));
    assign w_cnt_last   = (r_cnt == CNT_LAST);

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = in_wdata;
        case (in_func3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << in_addr[1:0];
                w_wdata = {4{in_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << {in_addr[1], 1'b0};
                w_wdata = {2{in_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = in_wdata;
            end
        endcase
    end

    // Load extension uses the lane and funct3 captured at request time,
    // since the pipeline inputs are not guaranteed to be examined again.
    always_comb begin
        w_byte = bus_rdata[{r_lane, 3'b000} +: 8];
        w_half = r_lane[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (r_func3[1:0])
            2'b00:   w_ext = r_func3[2] ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_ext = r_func3[2] ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_ext = bus_rdata;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    // Next-state logic; DONE never re-decodes the inputs still held upstream.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_access && !w_misaligned) w_next_state = S_REQ;
            S_REQ:   if (bus_ready || w_cnt_last)   w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        o_stall = ((r_state == S_IDLE) & w_access & ~w_misaligned)
                | (r_state == S_REQ);
    end

    // Registered bus side and result path
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req        <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_be         <= '0;
            r_wdata      <= '0;
            r_lane       <= '0;
            r_func3      <= '0;
            r_cnt        <= '0;
            r_rdata      <= '0;
            r_misaligned <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_misaligned <= 1'b0;
            r_timeout    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_access) begin
                        if (w_misaligned) begin
                            r_misaligned <= 1'b1;
                        end else begin
                            r_req   <= 1'b1;
                            r_we    <= in_wed;
                            r_addr  <= {in_addr[31:2], 2'b00};
                            r_be    <= w_be;
                            r_wdata <= w_wdata;
                            r_lane  <= in_addr[1:0];
                            r_func3 <= in_func3;
                            r_cnt   <= '0;
                        end
                    end
                end
                S_REQ: begin
                    if (bus_ready) begin
                        r_req <= 1'b0;
                        if (!r_we) r_rdata <= w_ext;
                    end else if (w_cnt_last) begin
                        r_req     <= 1'b0;
                        r_timeout <= 1'b1;
                        if (!r_we) r_rdata <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus_req       = r_req;
    assign bus_we        = r_we;
    assign bus_addr      = r_addr;
    assign bus_be        = r_be;
    assign bus_wdata     = r_wdata;
    assign o_read_data   = r_rdata;
    assign o_misaligned  = r_misaligned;
    assign o_bus_timeout = r_timeout;

endmodule
